// File: rtl/maxpool_pkg.sv
// Shared types for the max-pool sequencer: pixel type, FSM state encoding
// and the output map size helper.
package maxpool_pkg;

  localparam int PIXEL_W = 8;

  typedef logic signed [PIXEL_W-1:0] pixel_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_STREAM,
    ST_DRAIN,
    ST_NEXT,
    ST_FINISH
  } seq_state_t;

  // Pixels in one pooled (2x2, stride 2) output map.
  function automatic int out_map_size(input int map_width);
    return (map_width / 2) * (map_width / 2);
  endfunction

endpackage

// File: rtl/maxpool_addr_gen.sv
// Address generator: base + channel * stride + counter, wrapping modulo
// 2^ADDR_W. Used once for reads and once for writes.
module maxpool_addr_gen
  import maxpool_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int STRIDE = 784,
  parameter int CH_W   = 3,
  parameter int CNT_W  = 10
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [CH_W-1:0]   ch,
  input  logic [CNT_W-1:0]  cnt,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] ch_off;

  always_comb begin
    ch_off = ADDR_W'(ch) * ADDR_W'(STRIDE);
    addr   = base + ch_off + ADDR_W'(cnt);
  end

endmodule

// File: rtl/maxpool_sequencer.sv
// Job sequencer for an external 2x2 max-pool engine: streams each channel's
// input map from memory into the engine and writes the pooled results back.
module maxpool_sequencer
  import maxpool_pkg::*;
#(
  parameter int MAP_WIDTH     = 28,
  parameter int MAX_CH        = 6,
  parameter int ADDR_W        = 16,
  parameter int DRAIN_TIMEOUT = 500
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [$clog2(MAX_CH+1)-1:0]  num_ch,
  input  logic [ADDR_W-1:0]            in_base,
  input  logic [ADDR_W-1:0]            out_base,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic                         rd_en,
  output logic [ADDR_W-1:0]            rd_addr,
  input  pixel_t                       rd_data,
  output logic                         eng_rst,
  output logic                         eng_valid_in,
  output pixel_t                       eng_pixel_in,
  input  logic                         eng_valid_out,
  input  pixel_t                       eng_pixel_out,
  input  logic                         eng_all_done,
  output logic                         wr_en,
  output logic [ADDR_W-1:0]            wr_addr,
  output pixel_t                       wr_data,
  output seq_state_t                   state_dbg
);

  localparam int CH_W     = $clog2(MAX_CH + 1);
  localparam int IN_SIZE  = MAP_WIDTH * MAP_WIDTH;
  localparam int OUT_SIZE = out_map_size(MAP_WIDTH);
  localparam int CNT_W    = $clog2(IN_SIZE + 1);
  localparam int DRAIN_W  = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [CNT_W-1:0]   LAST_PIX   = CNT_W'(IN_SIZE - 1);
  localparam logic [CNT_W-1:0]   OUT_CNT    = CNT_W'(OUT_SIZE);
  localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CH_W-1:0]    MAX_CH_V   = CH_W'(MAX_CH);

  seq_state_t          state, state_nxt;
  logic [CH_W-1:0]     num_ch_q, ch, num_ch_clamped;
  logic [ADDR_W-1:0]   in_base_q, out_base_q;
  logic [CNT_W-1:0]    pix, k, k_inc;
  logic [DRAIN_W-1:0]  drain_cnt;
  logic                err_q, valid_in_q, active, write_window, last_ch;

  // Streams are valid-only: the engine takes a pixel on every cycle that
  // eng_valid_in is high, and every eng_valid_out inside STREAM/DRAIN is one
  // memory write; neither side can stall the other.

  assign num_ch_clamped = (num_ch > MAX_CH_V) ? MAX_CH_V : num_ch;
  assign last_ch        = (ch == num_ch_q - CH_W'(1));
  assign active         = !rst;
  assign write_window   = (state == ST_STREAM) || (state == ST_DRAIN);

  always_comb begin
    busy         = active && (state != ST_IDLE);
    done         = active && (state == ST_FINISH);
    err          = active && err_q;
    rd_en        = active && (state == ST_STREAM);
    eng_rst      = rst || (state == ST_CLEAR);
    eng_valid_in = active && valid_in_q;
    eng_pixel_in = rd_data;
    wr_en        = active && write_window && eng_valid_out;
    wr_data      = eng_pixel_out;
    k_inc        = k + CNT_W'(wr_en);
    state_dbg    = state;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = (num_ch_clamped == '0) ? ST_FINISH : ST_CLEAR;
      ST_CLEAR:  state_nxt = ST_STREAM;
      ST_STREAM: if (pix == LAST_PIX) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (eng_all_done)                   state_nxt = ST_NEXT;
        else if (drain_cnt == LAST_DRAIN)   state_nxt = ST_FINISH;
      end
      ST_NEXT:   state_nxt = last_ch ? ST_FINISH : ST_CLEAR;
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num_ch_q   <= '0;
      in_base_q  <= '0;
      out_base_q <= '0;
      ch         <= '0;
      pix        <= '0;
      k          <= '0;
      drain_cnt  <= '0;
      err_q      <= 1'b0;
      valid_in_q <= 1'b0;
    end else begin
      valid_in_q <= (state == ST_STREAM);
      case (state)
        ST_IDLE: begin
          if (start) begin
            num_ch_q   <= num_ch_clamped;
            in_base_q  <= in_base;
            out_base_q <= out_base;
            ch         <= '0;
            err_q      <= 1'b0;
          end
        end
        ST_CLEAR: begin
          pix       <= '0;
          k         <= '0;
          drain_cnt <= '0;
        end
        ST_STREAM: begin
          pix <= pix + CNT_W'(1);
          k   <= k_inc;
        end
        ST_DRAIN: begin
          k         <= k_inc;
          drain_cnt <= drain_cnt + DRAIN_W'(1);
          // A write landing with all_done is already folded into k_inc.
          if (eng_all_done) begin
            if (k_inc != OUT_CNT) err_q <= 1'b1;
          end else if (drain_cnt == LAST_DRAIN) begin
            err_q <= 1'b1;
          end
        end
        ST_NEXT: ch <= ch + CH_W'(1);
        default: ;
      endcase
    end
  end

  maxpool_addr_gen #(
    .ADDR_W (ADDR_W),
    .STRIDE (IN_SIZE),
    .CH_W   (CH_W),
    .CNT_W  (CNT_W)
  ) u_rd_addr (
    .base (in_base_q),
    .ch   (ch),
    .cnt  (pix),
    .addr (rd_addr)
  );

  maxpool_addr_gen #(
    .ADDR_W (ADDR_W),
    .STRIDE (OUT_SIZE),
    .CH_W   (CH_W),
    .CNT_W  (CNT_W)
  ) u_wr_addr (
    .base (out_base_q),
    .ch   (ch),
    .cnt  (k),
    .addr (wr_addr)
  );

endmodule
